// File: rtl/fetch_stage.sv
// Program counter and IF/ID pipeline register for the fetch stage.
// Applies one-hot next-PC selection and inserts NOP bubbles in the shadow of a redirect.
module fetch_stage #(
  parameter int unsigned          ADDR_W    = 9,
  parameter int unsigned          INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_VEC = '0,
  parameter logic [INSTR_W-1:0]   NOP       = '0,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         pc_sel,
  input  logic               load_pc,
  input  logic               load_if,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [ADDR_W-1:0]  reg_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_link,
  output logic               if_valid,
  output logic               sel_err,
  output logic [CNT_W-1:0]   fetch_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic [ADDR_W-1:0] pc_inc_c;
  logic [ADDR_W-1:0] pc_next_c;
  logic              sel_ok_c;
  logic              sel_rv_c;
  logic              bubble_c;

  assign imem_addr = pc;
  assign pc_inc_c  = pc + ADDR_W'(1);

  // Next-PC decode; any non-one-hot pattern (including X) lands in default.
  always_comb begin
    pc_next_c = pc;
    sel_ok_c  = 1'b0;
    sel_rv_c  = 1'b0;
    case (pc_sel)
      4'b0001: begin pc_next_c = RESET_VEC;     sel_ok_c = 1'b1; sel_rv_c = 1'b1; end
      4'b0010: begin pc_next_c = pc_inc_c;      sel_ok_c = 1'b1; end
      4'b0100: begin pc_next_c = branch_target; sel_ok_c = 1'b1; end
      4'b1000: begin pc_next_c = reg_target;    sel_ok_c = 1'b1; end
      default: ;
    endcase
  end

  // A reset-vector reload always bubbles so RESET_VEC is not issued twice.
  assign bubble_c = !load_if || (load_pc && sel_rv_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_VEC;
      if_instr   <= NOP;
      if_pc      <= '0;
      if_link    <= '0;
      if_valid   <= 1'b0;
      sel_err    <= 1'b0;
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (load_pc) begin
        if (sel_ok_c) pc      <= pc_next_c;
        else          sel_err <= 1'b1;
      end

      if (bubble_c) begin
        if_instr <= NOP;
        if_valid <= 1'b0;
        if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
      end else begin
        if_instr <= imem_rdata;
        if_pc    <= pc;
        if_link  <= pc_inc_c;
        if_valid <= 1'b1;
        if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of PC, IF/ID and counters.
module tb_fetch_stage;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int          RV      = 'h010;
  localparam int          AMOD    = 512;
  localparam int          CMAX    = 15;

  logic               clk = 1'b0;
  logic               reset;
  logic [3:0]         pc_sel;
  logic               load_pc;
  logic               load_if;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  reg_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic [ADDR_W-1:0]  if_link;
  logic               if_valid;
  logic               sel_err;
  logic [CNT_W-1:0]   fetch_cnt;
  logic [CNT_W-1:0]   bubble_cnt;

  logic [INSTR_W-1:0] mem [AMOD];

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_pc, m_ifpc, m_link, m_fc, m_bc;
  logic [15:0] m_instr;
  logic        m_valid, m_err;

  fetch_stage #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_VEC(9'h010), .NOP(16'h0000), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .pc_sel(pc_sel), .load_pc(load_pc), .load_if(load_if),
    .branch_target(branch_target), .reg_target(reg_target), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .pc(pc), .if_instr(if_instr), .if_pc(if_pc), .if_link(if_link),
    .if_valid(if_valid), .sel_err(sel_err), .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  // Model of one rising edge, evaluated from the inputs present before the edge.
  task automatic model_edge();
    bit onehot, bub;
    int old_pc;
    if (reset === 1'b1) begin
      m_pc = RV; m_instr = '0; m_ifpc = 0; m_link = 0;
      m_valid = 1'b0; m_err = 1'b0; m_fc = 0; m_bc = 0;
      return;
    end
    onehot = (pc_sel === 4'b0001) || (pc_sel === 4'b0010) ||
             (pc_sel === 4'b0100) || (pc_sel === 4'b1000);
    bub    = (load_if !== 1'b1) || (load_pc === 1'b1 && pc_sel === 4'b0001);
    old_pc = m_pc;
    if (bub) begin
      m_instr = '0;
      m_valid = 1'b0;
      m_bc    = (m_bc >= CMAX) ? CMAX : m_bc + 1;
    end else begin
      m_instr = mem[old_pc];
      m_ifpc  = old_pc;
      m_link  = (old_pc + 1) % AMOD;
      m_valid = 1'b1;
      m_fc    = (m_fc >= CMAX) ? CMAX : m_fc + 1;
    end
    if (load_pc === 1'b1) begin
      if (!onehot)                   m_err = 1'b1;
      else if (pc_sel === 4'b0001)   m_pc = RV;
      else if (pc_sel === 4'b0010)   m_pc = (old_pc + 1) % AMOD;
      else if (pc_sel === 4'b0100)   m_pc = int'(branch_target);
      else                           m_pc = int'(reg_target);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic lp, input logic li);
    pc_sel = s; load_pc = lp; load_if = li;
  endtask

  task automatic test_reset();
    reset = 1'b1; drive(4'b0000, 1'b0, 1'b0);
    tick(); tick();
    reset = 1'b0;
    checks++; if (pc !== 9'h010) begin errors++; $display("FAIL reset_pc got %h exp 010", pc); end
    checks++; if ({if_valid, sel_err, if_instr, if_pc, if_link, fetch_cnt, bubble_cnt} !== '0) begin
      errors++; $display("FAIL reset_state got v=%b e=%b i=%h p=%h l=%h f=%h b=%h exp all zero",
                         if_valid, sel_err, if_instr, if_pc, if_link, fetch_cnt, bubble_cnt); end
    drive(4'b0001, 1'b1, 1'b1); tick();
    checks++; if (pc !== 9'h010 || if_valid !== 1'b0 || if_instr !== 16'h0) begin
      errors++; $display("FAIL rv_reload got pc=%h v=%b i=%h exp pc=010 v=0 i=0000", pc, if_valid, if_instr); end
    drive(4'b0010, 1'b1, 1'b1); tick();
    checks++; if (pc !== 9'h011 || if_pc !== 9'h010 || if_valid !== 1'b1 || if_instr !== mem[16]) begin
      errors++; $display("FAIL first_fetch got pc=%h ifpc=%h v=%b i=%h exp pc=011 ifpc=010 v=1 i=%h",
                         pc, if_pc, if_valid, if_instr, mem[16]); end
    checks++; if (fetch_cnt !== 4'd1 || bubble_cnt !== 4'd1) begin
      errors++; $display("FAIL reset_counts got f=%0d b=%0d exp f=1 b=1", fetch_cnt, bubble_cnt); end
  endtask

  task automatic test_sequential_wrap();
    logic [ADDR_W-1:0] exp_pc [3];
    exp_pc[0] = 9'h1FE; exp_pc[1] = 9'h1FF; exp_pc[2] = 9'h000;
    branch_target = 9'h1FE; drive(4'b0100, 1'b1, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0010, 1'b1, 1'b1); tick();
      checks++; if (if_pc !== exp_pc[i] || if_valid !== 1'b1 || if_instr !== mem[exp_pc[i]]) begin
        errors++; $display("FAIL seq_ifpc[%0d] got ifpc=%h v=%b i=%h exp ifpc=%h v=1 i=%h",
                           i, if_pc, if_valid, if_instr, exp_pc[i], mem[exp_pc[i]]); end
      if (i == 1) begin
        checks++; if (if_link !== 9'h000) begin errors++; $display("FAIL wrap_link got %h exp 000", if_link); end
      end
    end
    checks++; if (pc !== 9'h001) begin errors++; $display("FAIL wrap_pc got %h exp 001", pc); end
  endtask

  task automatic test_taken_branch();
    branch_target = 9'h020; drive(4'b0100, 1'b1, 1'b0); tick();
    checks++; if (pc !== 9'h020) begin errors++; $display("FAIL br_setup got %h exp 020", pc); end
    branch_target = 9'h080; drive(4'b0100, 1'b1, 1'b0); tick();
    checks++; if (if_valid !== 1'b0 || if_instr !== 16'h0 || pc !== 9'h080) begin
      errors++; $display("FAIL br_bubble got v=%b i=%h pc=%h exp v=0 i=0000 pc=080", if_valid, if_instr, pc); end
    drive(4'b0010, 1'b1, 1'b1); tick();
    checks++; if (if_pc !== 9'h080 || pc !== 9'h081 || if_valid !== 1'b1 || if_instr !== mem[128]) begin
      errors++; $display("FAIL br_target got ifpc=%h pc=%h v=%b i=%h exp ifpc=080 pc=081 v=1 i=%h",
                         if_pc, pc, if_valid, if_instr, mem[128]); end
  endtask

  task automatic test_reg_branch();
    reg_target = 9'h0C3; drive(4'b1000, 1'b1, 1'b0); tick();
    checks++; if (pc !== 9'h0C3 || if_valid !== 1'b0) begin
      errors++; $display("FAIL blx_load got pc=%h v=%b exp pc=0c3 v=0", pc, if_valid); end
    drive(4'b0010, 1'b1, 1'b1); tick();
    checks++; if (if_pc !== 9'h0C3 || if_link !== 9'h0C4 || if_valid !== 1'b1) begin
      errors++; $display("FAIL blx_link got ifpc=%h link=%h v=%b exp ifpc=0c3 link=0c4 v=1", if_pc, if_link, if_valid); end
  endtask

  task automatic test_halt_saturation();
    int exp_b;
    reset = 1'b1; drive(4'b0010, 1'b1, 1'b1); tick(); reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      drive(4'bxxxx, 1'b0, 1'b0); tick();
      exp_b = (i > CMAX) ? CMAX : i;
      checks++; if (pc !== 9'h010 || if_valid !== 1'b0 || sel_err !== 1'b0) begin
        errors++; $display("FAIL halt_state[%0d] got pc=%h v=%b e=%b exp pc=010 v=0 e=0", i, pc, if_valid, sel_err); end
      checks++; if (bubble_cnt !== CNT_W'(exp_b) || fetch_cnt !== 4'd0) begin
        errors++; $display("FAIL halt_cnt[%0d] got b=%0d f=%0d exp b=%0d f=0", i, bubble_cnt, fetch_cnt, exp_b); end
    end
  endtask

  task automatic test_illegal_sel();
    branch_target = 9'h055; drive(4'b0100, 1'b1, 1'b0); tick();
    drive(4'b0110, 1'b1, 1'b1); tick();
    checks++; if (pc !== 9'h055 || sel_err !== 1'b1) begin
      errors++; $display("FAIL illegal_sel got pc=%h e=%b exp pc=055 e=1", pc, sel_err); end
    drive(4'b0010, 1'b1, 1'b1); tick(); tick();
    checks++; if (sel_err !== 1'b1 || pc !== 9'h057) begin
      errors++; $display("FAIL sticky_err got e=%b pc=%h exp e=1 pc=057", sel_err, pc); end
    reset = 1'b1; branch_target = 9'h1AA; drive(4'b0100, 1'b1, 1'b1); tick(); reset = 1'b0;
    checks++; if (sel_err !== 1'b0 || pc !== 9'h010 || if_valid !== 1'b0) begin
      errors++; $display("FAIL reset_recover got e=%b pc=%h v=%b exp e=0 pc=010 v=0", sel_err, pc, if_valid); end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0:       pc_sel = 4'b0001;
        1, 2:    pc_sel = 4'b0100;
        3:       pc_sel = 4'b1000;
        4:       pc_sel = 4'($urandom);
        default: pc_sel = 4'b0010;
      endcase
      load_pc       = ($urandom_range(0, 7) != 0);
      load_if       = ($urandom_range(0, 3) != 0);
      if (pc_sel == 4'b0001) load_pc = 1'b1;
      branch_target = ADDR_W'($urandom);
      reg_target    = ADDR_W'($urandom);
      reset         = ($urandom_range(0, 63) == 0);
      tick();
      checks++;
      if ({imem_addr, pc, if_instr, if_pc, if_link, if_valid, sel_err, fetch_cnt, bubble_cnt} !==
          {9'(m_pc), 9'(m_pc), m_instr, 9'(m_ifpc), 9'(m_link), m_valid, m_err, 4'(m_fc), 4'(m_bc)}) begin
        errors++;
        $display("FAIL rand[%0d] got a=%h pc=%h i=%h ip=%h l=%h v=%b e=%b f=%0d b=%0d exp pc=%h i=%h ip=%h l=%h v=%b e=%b f=%0d b=%0d",
                 n, imem_addr, pc, if_instr, if_pc, if_link, if_valid, sel_err, fetch_cnt, bubble_cnt,
                 m_pc, m_instr, m_ifpc, m_link, m_valid, m_err, m_fc, m_bc);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < AMOD; i++) mem[i] = INSTR_W'($urandom_range(1, 65535));
    reset = 1'b1; pc_sel = 4'b0000; load_pc = 1'b0; load_if = 1'b0;
    branch_target = '0; reg_target = '0;
    m_pc = RV; m_instr = '0; m_ifpc = 0; m_link = 0; m_valid = 1'b0; m_err = 1'b0; m_fc = 0; m_bc = 0;
    #1;
    test_reset();
    test_sequential_wrap();
    test_taken_branch();
    test_reg_branch();
    test_halt_saturation();
    test_illegal_sel();
    reset = 1'b1; drive(4'b0000, 1'b0, 1'b0); tick(); reset = 1'b0;
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Program-counter and instruction-fetch stage that sits directly downstream of the branch control unit. It consumes the one-hot `pc_sel`, `load_pc` and `load_if` strobes to update the PC and to drive instruction-memory addressing. It also maintains the IF/ID pipeline register, inserting NOP bubbles into the shadow of a redirect. Fetch and bubble counters are kept for performance debug.

## Interface
- `ADDR_W`, 9 — PC / instruction-address width.
- `INSTR_W`, 16 — instruction width.
- `RESET_VEC`, 0 — PC value on reset and on `pc_sel`=0001.
- `NOP`, {INSTR_W{1'b0}} — encoding injected on a bubble.
- `CNT_W`, 16 — performance counter width.

Ports:
- `clk` in 1 — single clock; all state updates on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `pc_sel` in 4 — one-hot next-PC select:
  - 0001: `RESET_VEC`
  - 0010: PC+1
  - 0100: `branch_target`
  - 1000: `reg_target`
- `load_pc` in 1 — PC write enable.
- `load_if` in 1 — 1 captures the fetched instruction into IF/ID; 0 inserts a bubble.
- `branch_target` in ADDR_W — PC-relative target computed in decode.
- `reg_target` in ADDR_W — register target for BX/BLX.
- `imem_addr` out ADDR_W — instruction-memory address; combinational, equals `pc`.
- `imem_rdata` in INSTR_W — combinational-read instruction-memory data for `imem_addr`.
- `pc` out ADDR_W — current PC register.
- `if_instr` out INSTR_W — IF/ID instruction.
- `if_pc` out ADDR_W — address of `if_instr`.
- `if_link` out ADDR_W — `if_pc`+1, the return address for BL/BLX.
- `if_valid` out 1 — IF/ID holds a real instruction.
- `sel_err` out 1 — sticky flag: `pc_sel` was not one-hot while `load_pc`=1.
- `fetch_cnt` out CNT_W — count of valid IF/ID captures.
- `bubble_cnt` out CNT_W — count of bubble insertions.

## Operation
- **Next-PC mux.** One-hot decode of `pc_sel`. PC+1 wraps modulo 2^ADDR_W (max address → 0).
- **PC update.**
  - `load_pc`=1 with a one-hot `pc_sel`: `pc` ← selected value.
  - `load_pc`=1 with a non-one-hot `pc_sel` (including 0000 and X): `pc` holds and `sel_err` ← 1.
  - `load_pc`=0: `pc` holds and `pc_sel` is ignored, even if X.
- **IF/ID capture.** When `load_if`=1 and `pc_sel`≠0001:
  - `if_instr` ← `imem_rdata`
  - `if_pc` ← `pc`
  - `if_link` ← `pc`+1 (wrapping)
  - `if_valid` ← 1
- **Bubble insertion.** When `load_if`=0, or when `pc_sel`=0001 with `load_pc`=1:
  - `if_instr` ← `NOP`
  - `if_valid` ← 0
  - `if_pc` and `if_link` hold
  - The reset-vector reload always bubbles. This prevents the instruction at `RESET_VEC` being issued twice.
- **Counters.** `fetch_cnt` increments on each valid capture; `bubble_cnt` increments on each bubble. Both saturate at all-ones and never wrap.
- **Halt.** With `load_pc`=0 and `load_if`=0 held, the PC freezes and IF/ID streams bubbles. `bubble_cnt` continues to count, saturating.
- **Sticky error.** `sel_err` is cleared only by `reset`.

## Timing
- **Reset values.** Applied at the edge where `reset`=1, overriding all other inputs; reset mid-operation discards any in-flight redirect.
  - `pc`=`RESET_VEC`
  - `if_instr`=`NOP`
  - `if_pc`=0
  - `if_link`=0
  - `if_valid`=0
  - `sel_err`=0
  - both counters=0
- **Fetch latency.** Zero-cycle address: `imem_addr` follows `pc` combinationally. The instruction appears in IF/ID one edge after `pc` holds its address.
- **Redirect.**
  - At edge N, a cycle with `pc_sel`=0100/1000 and `load_if`=0 loads the target into `pc` and bubbles IF/ID, squashing the sequential fetch.
  - At edge N+1, with `pc_sel`=0010 and `load_if`=1, IF/ID captures the instruction at the target and `pc` becomes target+1.
- **Simultaneous events.** `reset` beats everything. A bubble and a PC load may occur on the same edge; each is applied independently.
- **Output registration.** No combinational path from `pc_sel`/`load_*` to any output; all outputs are registered except `imem_addr`.

## Test plan
- **Reset sequencing.** Assert `reset` 2 cycles with `RESET_VEC`=0x010, then drive 0001/1/1 for 1 cycle followed by 0010/1/1. Required: `pc` goes 0x010 → 0x010 → 0x011. The first IF/ID entry is a bubble; the second is `if_pc`=0x010 with `if_valid`=1. `fetch_cnt`=1 and `bubble_cnt`=1.
- **Sequential fetch and wrap.** Preload `pc`=0x1FE, then issue 3 cycles of 0010/1/1. Required: `if_pc` sequence 0x1FE, 0x1FF, 0x000; `if_link` of 0x1FF is 0x000; `pc` ends at 0x001.
- **Taken branch.** At `pc`=0x020, drive 0100/1/0 with `branch_target`=0x080, then 0010/1/1. Required: bubble first with `if_valid`=0 and `if_instr`=`NOP`, then `if_pc`=0x080 and `pc`=0x081.
- **Register branch (BLX).** Drive 1000/1/0 with `reg_target`=0x0C3, then 0010/1/1. Required: `if_pc`=0x0C3 and `if_link`=0x0C4.
- **Halt and saturation.** With `CNT_W`=4, hold `load_pc`=0, `load_if`=0 and `pc_sel`=X for 20 cycles. Required: `pc` is constant, `if_valid`=0 throughout, `bubble_cnt` reaches 0xF and stays there, and `sel_err`=0.
- **Illegal select and reset recovery.** Drive `pc_sel`=0110 with `load_pc`=1. Required: `pc` unchanged and `sel_err`=1, staying set. Then assert `reset` for 1 cycle mid-stream. Required: `sel_err`=0, `pc`=`RESET_VEC`, `if_valid`=0.
